// File: rtl/uart_mmio_fifo_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS bit
// positions, divisor floor and serializer state encodings.
package uart_mmio_fifo_pkg;

   localparam logic [11:0] REG_DATA   = 12'h000;
   localparam logic [11:0] REG_STATUS = 12'h004;
   localparam logic [11:0] REG_DIV    = 12'h008;
   localparam logic [11:0] REG_IRQ_EN = 12'h00C;

   localparam int ST_TX_IDLE  = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_RX_VALID = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_TX_OVF   = 4;
   localparam int ST_RX_OVR   = 5;
   localparam int ST_FRM_ERR  = 6;

   localparam logic [15:0] MIN_DIV = 16'd4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < MIN_DIV) ? MIN_DIV : v;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; a simultaneous push and pop keeps
// the count unchanged even when full or empty (empty case bypasses wdata).
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign do_push = push_i & (~full_o | pop_i);
   assign do_pop  = pop_i & (~empty_o | push_i);
   assign rdata_o = empty_o ? wdata_i : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, programmable divisor, sticky
// error flags and a level interrupt.
module uart_mmio_fifo
   import uart_mmio_fifo_pkg::*;
#(
   parameter int unsigned TX_DEPTH    = 16,
   parameter int unsigned RX_DEPTH    = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        uart_tx_pin,
   input  logic        uart_rx_pin,
   output logic        irq
);

   logic        bus_wr, bus_rd;
   logic [11:0] bus_addr;
   logic        unused_bits;

   logic [15:0] div_q, div_d;
   logic [1:0]  irq_en_q, irq_en_d;
   logic        tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d;
   logic [31:0] rdata_q, rdata_d, status;
   logic        irq_q, irq_d;

   logic        tx_push, tx_pop, tx_empty, tx_full, tx_idle;
   logic [7:0]  tx_head;
   logic        rx_push, rx_pop, rx_empty, rx_full, rx_valid, frm_set;
   logic [7:0]  rx_head;

   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_pin_q, tx_pin_d, tx_bit_end;

   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_bit_end;

   assign bus_wr      = data_sram_en & (|data_sram_wen);
   assign bus_rd      = data_sram_en & ~(|data_sram_wen);
   assign bus_addr    = data_sram_addr[11:0];
   assign unused_bits = ^{data_sram_addr[31:12], data_sram_wdata[31:16]};

   assign tx_push  = bus_wr & (bus_addr == REG_DATA);
   assign rx_pop   = bus_rd & (bus_addr == REG_DATA) & ~rx_empty;
   assign rx_valid = ~rx_empty;
   assign tx_idle  = tx_empty & (tx_state_q == TX_IDLE);

   uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tx_push),
      .wdata_i (data_sram_wdata[7:0]),
      .pop_i   (tx_pop),
      .rdata_o (tx_head),
      .empty_o (tx_empty),
      .full_o  (tx_full)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rx_push),
      .wdata_i (rx_shift_q),
      .pop_i   (rx_pop),
      .rdata_o (rx_head),
      .empty_o (rx_empty),
      .full_o  (rx_full)
   );

   always_comb begin
      status              = '0;
      status[ST_TX_IDLE]  = tx_idle;
      status[ST_TX_FULL]  = tx_full;
      status[ST_RX_VALID] = rx_valid;
      status[ST_RX_FULL]  = rx_full;
      status[ST_TX_OVF]   = tx_ovf_q;
      status[ST_RX_OVR]   = rx_ovr_q;
      status[ST_FRM_ERR]  = frm_err_q;
   end

   // Register file; sticky sets win over a same-cycle W1C clear.
   always_comb begin
      rdata_d  = '0;
      div_d    = div_q;
      irq_en_d = irq_en_q;
      tx_ovf_d = tx_ovf_q;
      rx_ovr_d = rx_ovr_q;
      frm_err_d = frm_err_q;
      if (bus_rd) begin
         case (bus_addr)
            REG_DATA:   rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
            REG_STATUS: rdata_d = status;
            REG_DIV:    rdata_d = {16'd0, div_q};
            REG_IRQ_EN: rdata_d = {30'd0, irq_en_q};
            default:    rdata_d = '0;
         endcase
      end
      if (bus_wr) begin
         case (bus_addr)
            REG_STATUS: begin
               if (data_sram_wdata[ST_TX_OVF])  tx_ovf_d  = 1'b0;
               if (data_sram_wdata[ST_RX_OVR])  rx_ovr_d  = 1'b0;
               if (data_sram_wdata[ST_FRM_ERR]) frm_err_d = 1'b0;
            end
            REG_DIV:    div_d    = clamp_div(data_sram_wdata[15:0]);
            REG_IRQ_EN: irq_en_d = data_sram_wdata[1:0];
            default:    ;
         endcase
      end
      if (tx_push && tx_full && !tx_pop) tx_ovf_d  = 1'b1;
      if (rx_push && rx_full && !rx_pop) rx_ovr_d  = 1'b1;
      if (frm_set)                       frm_err_d = 1'b1;
      irq_d = (irq_en_q[0] & rx_valid) | (irq_en_q[1] & tx_idle);
   end

   assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);

   // Serializer: pin is registered alongside the next state.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_div_d   = tx_div_q;
      tx_pin_d   = tx_pin_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            tx_pin_d = 1'b1;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_div_d   = div_q;
               tx_state_d = TX_START;
               tx_pin_d   = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
               tx_pin_d   = tx_shift_q[0];
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  tx_pin_d   = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_pin_d   = tx_shift_q[1];
               end
            end
         end
         default: begin
            if (tx_bit_end) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
               tx_pin_d   = 1'b1;
            end
         end
      endcase
   end

   assign rx_half    = {1'b0, rx_div_q[15:1]};
   assign rx_bit_end = (rx_cnt_q == rx_div_q - 16'd1);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 16'd1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_div_d   = rx_div_q;
      rx_push    = 1'b0;
      frm_set    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = RX_START;
               rx_div_d   = div_q;
            end
         end
         RX_START: begin
            // Mid-start check rejects short glitches.
            if (rx_cnt_q == rx_half - 16'd1) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         default: begin
            if (rx_bit_end) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               rx_push    = rx_s2_q;
               frm_set    = ~rx_s2_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q      <= DEFAULT_DIV;
         irq_en_q   <= '0;
         tx_ovf_q   <= 1'b0;
         rx_ovr_q   <= 1'b0;
         frm_err_q  <= 1'b0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_div_q   <= DEFAULT_DIV;
         tx_pin_q   <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_div_q   <= DEFAULT_DIV;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         div_q      <= div_d;
         irq_en_q   <= irq_en_d;
         tx_ovf_q   <= tx_ovf_d;
         rx_ovr_q   <= rx_ovr_d;
         frm_err_q  <= frm_err_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_div_q   <= tx_div_d;
         tx_pin_q   <= tx_pin_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_div_q   <= rx_div_d;
         rx_s1_q    <= uart_rx_pin;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
      end
   end

   assign data_sram_rdata = rdata_q;
   assign uart_tx_pin     = tx_pin_q;
   assign irq             = irq_q;

endmodule

// File: doc/uart_mmio_fifo.md
UART_MMIO_FIFO -- requirements
Module: uart_mmio_fifo

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 16, meaning TX FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter RX_DEPTH, default 16, meaning RX FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter DEFAULT_DIV, default 16'd868, meaning reset value of the baud divisor in clk cycles per bit.
REQ-004 SHALL provide ports:
- clk  in  1  sole clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- data_sram_en  in  1  bus access strobe.
- data_sram_wen  in  4  byte write enables; any bit set means write, zero means read.
- data_sram_addr  in  32  byte address; only bits [11:0] decoded.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  registered read data.
- uart_tx_pin  out  1  serial output, idle high.
- uart_rx_pin  in  1  serial input, asynchronous.
- irq  out  1  level interrupt.

Function
REQ-005 SHALL decode four registers:
- 0x000 DATA: write pushes wdata[7:0] to the TX FIFO; read pops the RX FIFO.
- 0x004 STATUS: read-only except for W1C bits.
- 0x008 DIV: bits [15:0].
- 0x00C IRQ_EN: bits [1:0].
REQ-006 SHALL return read data on data_sram_rdata exactly 1 cycle after the read access; rdata SHALL be 0 in every cycle not following a read, and 0 for undecoded addresses.
REQ-007 STATUS layout SHALL be:
- [0] tx_idle: TX FIFO empty and serializer in IDLE.
- [1] tx_full.
- [2] rx_valid: RX FIFO non-empty.
- [3] rx_full.
- [4] tx_ovf: sticky, W1C.
- [5] rx_ovr: sticky, W1C.
- [6] frm_err: sticky, W1C.
- all other bits 0.
REQ-008 DATA read with RX FIFO empty SHALL return 0 and SHALL NOT change FIFO state; a non-empty read SHALL return {24'b0, byte}.
REQ-009 DATA write with TX FIFO full SHALL drop the byte and set tx_ovf.
REQ-010 FIFOs SHALL support a push and a pop in the same cycle, both when full and when empty, with the count unchanged; pointers SHALL wrap modulo depth.
REQ-011 DIV writes SHALL be clamped to a minimum of 4; TX and RX SHALL latch DIV at each frame start, so a write during a frame affects only later frames.
REQ-012 TX frame format SHALL be 8N1, LSB first; TX FSM SHALL follow IDLE -> START -> DATA(8 bits) -> STOP -> IDLE, with each bit lasting exactly DIV cycles.
REQ-013 TX SHALL pop the FIFO in IDLE when the FIFO is non-empty and enter START the next cycle; back-to-back bytes SHALL be separated by at most 1 idle cycle.
REQ-014 RX input SHALL pass through a 2-flop synchronizer.
REQ-015 RX FSM SHALL follow IDLE -> START -> DATA -> STOP:
- A falling edge in IDLE enters START.
- Line still low at DIV/2 enters DATA; line high returns to IDLE (glitch rejected).
- Each data bit is sampled every DIV cycles thereafter.
REQ-016 RX stop-bit handling:
- Stop bit high: push the byte.
- Stop bit low: drop the byte and set frm_err.
- Push to a full RX FIFO: drop the byte and set rx_ovr.
REQ-017 irq SHALL equal (IRQ_EN[0] & rx_valid) | (IRQ_EN[1] & tx_idle), registered.
REQ-018 A same-cycle sticky set and W1C clear SHALL leave the bit set.

Reset
REQ-019 While rst is high at a clk edge, the block SHALL apply:
- FIFOs empty.
- FSMs IDLE.
- uart_tx_pin = 1.
- data_sram_rdata = 0.
- irq = 0.
- sticky bits = 0.
- IRQ_EN = 0.
- DIV = DEFAULT_DIV.
REQ-020 Reset mid-frame SHALL abort the frame immediately; uart_tx_pin SHALL be high on the cycle after the reset edge.

Structure
REQ-021 A shared package SHALL hold register offsets, STATUS bit indices, MIN_DIV = 4, and the TX/RX FSM state encodings.
REQ-022 One sub-module, uart_sync_fifo (parameters WIDTH and DEPTH), SHALL be instantiated twice; the serializers SHALL remain inline.

Verification
REQ-023 DIV = 4, write 0x55 then 0xA3 -> uart_tx_pin shows 0,1,0,1,0,1,0,1,0,1 then 0,1,1,0,0,0,1,0,1,1, each bit 4 cycles, at most 1 idle cycle between frames.
REQ-024 TX_DEPTH = 4, serializer mid-frame, 6 writes -> tx_full=1, tx_ovf=1, exactly 5 bytes transmitted; writing STATUS 0x10 clears tx_ovf.
REQ-025 Drive RX frame 0x3C at DIV = 8 -> rx_valid=1, irq=1 with IRQ_EN=1; DATA read returns 0x3C one cycle later; next DATA read returns 0.
REQ-026 A 2-cycle low RX glitch -> no byte received and no flags set; a frame with stop bit low -> frm_err=1 and RX FIFO empty.
REQ-027 RX_DEPTH+1 frames without reads -> rx_full=1, rx_ovr=1, and the first RX_DEPTH bytes read back in order.
REQ-028 Assert rst during TX DATA state -> uart_tx_pin=1 next cycle, STATUS reads 0x01, DIV reads DEFAULT_DIV.
